hazard_scoreboard: RTL

Parametrised hazard and forwarding unit for the MIPS pipeline, sitting beside ID. It tracks every in-flight register writer in a shift table of `FWD_DEPTH` stages after ID and returns forwarded `rs`/`rt` operands from the youngest producer. It asserts `stall` when that producer's result is not yet available, e.g. a load-use hazard. It also maintains the LL/SC link flag that drives `atomic_id` and store-conditional masking.

---
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : ID-side hazard/forwarding unit with in-flight writer table and
//            LL/SC link flag (link logic enabled by macro HAZARD_LLSC_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic                      id_valid,
  input  logic                      id_kill,
  input  logic [4:0]                id_rs_addr,
  input  logic [4:0]                id_rt_addr,
  input  logic                      id_reads_rs,
  input  logic                      id_reads_rt,
  input  logic                      id_we,
  input  logic [4:0]                id_wr_addr,
  input  logic                      id_is_load,
  input  logic                      id_is_ll,
  input  logic                      id_is_store,
  input  logic                      id_is_sc,
  input  logic [XLEN-1:0]           rs_rf_data,
  input  logic [XLEN-1:0]           rt_rf_data,
  input  logic [FWD_DEPTH*XLEN-1:0] stg_data,
  output logic [XLEN-1:0]           rs_data,
  output logic [XLEN-1:0]           rt_data,
  output logic                      stall,
  output logic                      atomic_id,
  output logic                      mem_sc_mask_id
);

  logic [FWD_DEPTH-1:0]      r_v;
  logic [FWD_DEPTH-1:0]      r_ld;
  logic [FWD_DEPTH-1:0][4:0] r_addr;

  logic            w_rs_hit, w_rs_rdy, w_rt_hit, w_rt_rdy;
  logic [XLEN-1:0] w_rs_fwd, w_rt_fwd;
  logic            w_rs_nrdy, w_rt_nrdy;

  // Walk oldest to youngest so the lowest matching stage has the final say.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rs_rdy = 1'b0;
    w_rs_fwd = '0;
    w_rt_hit = 1'b0;
    w_rt_rdy = 1'b0;
    w_rt_fwd = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (r_v[k] && (r_addr[k] == id_rs_addr) && (id_rs_addr != 5'd0)) begin
        w_rs_hit = 1'b1;
        w_rs_rdy = !r_ld[k] || (k >= LOAD_LAT);
        w_rs_fwd = stg_data[k*XLEN +: XLEN];
      end
      if (r_v[k] && (r_addr[k] == id_rt_addr) && (id_rt_addr != 5'd0)) begin
        w_rt_hit = 1'b1;
        w_rt_rdy = !r_ld[k] || (k >= LOAD_LAT);
        w_rt_fwd = stg_data[k*XLEN +: XLEN];
      end
    end
  end

  assign w_rs_nrdy = w_rs_hit & ~w_rs_rdy;
  assign w_rt_nrdy = w_rt_hit & ~w_rt_rdy;

  assign rs_data = (w_rs_hit && w_rs_rdy) ? w_rs_fwd : rs_rf_data;
  assign rt_data = (w_rt_hit && w_rt_rdy) ? w_rt_fwd : rt_rf_data;

  assign stall = id_valid & ~id_kill &
                 ((id_reads_rs & w_rs_nrdy) | (id_reads_rt & w_rt_nrdy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_ld   <= '0;
      r_addr <= '0;
    end else if (!hold) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        r_v[k]    <= r_v[k-1];
        r_ld[k]   <= r_ld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
      // A stalled instruction enters as a bubble so it can never match itself.
      r_v[0]    <= id_valid & id_we & ~id_kill & ~stall;
      r_ld[0]   <= id_is_load | id_is_ll;
      r_addr[0] <= id_wr_addr;
    end
  end

`ifdef HAZARD_LLSC_EN
  logic w_accept;
  logic r_link;

  assign w_accept = id_valid & ~id_kill & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link <= 1'b0;
    end else if (!hold && w_accept) begin
      if (id_is_store || id_is_sc) begin
        r_link <= 1'b0;
      end else if (id_is_ll) begin
        r_link <= 1'b1;
      end
    end
  end

  assign atomic_id      = r_link;
  assign mem_sc_mask_id = id_is_sc & ~r_link;
`else
  logic w_unused_store;
  assign w_unused_store = id_is_store;
  assign atomic_id      = 1'b0;
  assign mem_sc_mask_id = id_is_sc;
`endif

endmodule

`default_nettype wire
